pc_next_unit: RTL and testbench
===============================

PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 SHALL take parameter WIDTH, default 32, PC and target width in bits.
REQ-002 SHALL take parameter RESET_PC, default 32'h0000_3000, PC value loaded by reset.
REQ-003 SHALL take parameter EXC_VEC, default 32'h0000_4180, exception handler entry address.
REQ-004 SHALL have port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: stall  in  1  hold PC (fetch/decode stall).
REQ-007 SHALL have port: br_taken  in  1  branch instruction with condition true.
REQ-008 SHALL have port: br_target  in  WIDTH  branch target.
REQ-009 SHALL have port: jump  in  1  j/jal.
REQ-010 SHALL have port: j_target  in  WIDTH  jump target.
REQ-011 SHALL have port: jreg  in  1  jr/jalr.
REQ-012 SHALL have port: jr_target  in  WIDTH  register target.
REQ-013 SHALL have port: exc  in  1  exception request.
REQ-014 SHALL have port: eret  in  1  exception return.
REQ-015 SHALL have port: epc  in  WIDTH  return address for eret.
REQ-016 SHALL have port: pc  out  WIDTH  current PC (register output).
REQ-017 SHALL have port: pc_op  out  3  combinational select code of the current cycle.
REQ-018 SHALL have port: pend_v  out  1  buffered redirect waiting for stall release.
REQ-019 SHALL have port: misalign  out  1  registered misaligned-target flag.

Function
REQ-020 SHALL select the source by fixed priority: exc > eret > pending > br_taken > jump > jreg > sequential.
REQ-021 SHALL drive pc_op as 000 seq, 001 branch, 010 jump, 011 jreg, 100 exc, 101 eret, 110 pending.
REQ-022 SHALL compute the sequential value as pc+4, modulo 2^WIDTH (wrap-around, no flag).
REQ-023 SHALL load the selected value into pc on the next rising edge (1-cycle latency) when stall=0.
REQ-024 SHALL hold pc when stall=1, except when exc or eret is asserted.
REQ-025 SHALL load EXC_VEC (exc) or epc (eret) regardless of stall, and clear pend_v in the same edge.
REQ-026 SHALL, when stall=1, pend_v=0 and a branch/jump/jreg request is asserted, latch that request's target into the pending register and set pend_v; the following edge leaves pc unchanged.
REQ-027 SHALL ignore branch/jump/jreg requests while pend_v=1; the first buffered redirect is retained.
REQ-028 SHALL, on the first edge with stall=0 and pend_v=1, load the pending target into pc and clear pend_v; any simultaneous branch/jump/jreg request is discarded.
REQ-029 SHALL report pc_op=000 while stall=1 with no exc/eret and no new redirect being buffered; a redirect being buffered reports its own code.

Reset
REQ-030 SHALL, on rst_n low, asynchronously set pc=RESET_PC, pend_v=0, pending register=0, misalign=0.
REQ-031 SHALL discard a pending redirect when reset asserts mid-stall; after release, fetch resumes from RESET_PC.
REQ-032 SHALL perform its first update on the first rising edge after rst_n goes high.

Configuration
REQ-033 SHALL, with PC_ALIGN_CHECK_EN defined, treat a branch/jump/jreg/pending target whose bits [1:0] are nonzero as misaligned: load EXC_VEC instead of the target and set misalign for exactly one cycle.
REQ-034 SHALL, with PC_ALIGN_CHECK_EN defined, apply the check when the target is loaded into pc, not when it is buffered.
REQ-035 SHALL, without PC_ALIGN_CHECK_EN, load all targets unchanged and tie misalign to 0; the port list is identical in both builds.

Verification
REQ-036 SHALL verify: reset release, no requests, 3 edges -> pc=3000,3004,3008,300C; pc_op=000.
REQ-037 SHALL verify: br_taken=1 and jump=1 in the same cycle, br_target=3100, j_target=3200 -> pc_op=001; next pc=3100.
REQ-038 SHALL verify: stall=1 with jreg=1, jr_target=3400, then jump=1 on the next cycle, then stall=0 -> pend_v=1 for 2 cycles; pc=3400 after release; pc_op=110 on the release cycle.
REQ-039 SHALL verify: stall=1, pend_v=1, exc=1 -> next pc=4180 and pend_v=0; eret=1 with epc=3010 -> next pc=3010.
REQ-040 SHALL verify: pc=FFFFFFFC, no requests -> next pc=00000000.
REQ-041 SHALL verify: with PC_ALIGN_CHECK_EN defined, jump=1 and j_target=3202 -> pc=4180 and misalign=1 for one cycle; without the macro -> pc=3202 and misalign=0.

Source files
------------

// File: rtl/pc_next_unit.sv
// Next-PC selection and PC register with a one-entry buffer for redirects that arrive during a stall.
// Optional build macro PC_ALIGN_CHECK_EN turns misaligned redirect targets into a jump to EXC_VEC.
module pc_next_unit #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
   parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(32'h0000_4180)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   input  logic             jump,
   input  logic [WIDTH-1:0] j_target,
   input  logic             jreg,
   input  logic [WIDTH-1:0] jr_target,
   input  logic             exc,
   input  logic             eret,
   input  logic [WIDTH-1:0] epc,
   output logic [WIDTH-1:0] pc,
   output logic [2:0]       pc_op,
   output logic             pend_v,
   output logic             misalign
);

   typedef enum logic [2:0] {
      OP_SEQ  = 3'b000,
      OP_BR   = 3'b001,
      OP_JMP  = 3'b010,
      OP_JR   = 3'b011,
      OP_EXC  = 3'b100,
      OP_ERET = 3'b101,
      OP_PEND = 3'b110
   } pc_op_e;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             pend_v_q, pend_v_d;
   logic [WIDTH-1:0] redirTgt;
   logic [WIDTH-1:0] loadTgt;
   logic [WIDTH-1:0] pcSeq;
   pc_op_e           redirOp;
   pc_op_e           op;
   logic             tgtLoad;

   always_comb begin
      redirOp  = OP_SEQ;
      redirTgt = '0;
      if (br_taken) begin
         redirOp  = OP_BR;
         redirTgt = br_target;
      end else if (jump) begin
         redirOp  = OP_JMP;
         redirTgt = j_target;
      end else if (jreg) begin
         redirOp  = OP_JR;
         redirTgt = jr_target;
      end
   end

   // During a stall only a redirect that is actually being buffered shows its code.
   always_comb begin
      op = OP_SEQ;
      if (exc)
         op = OP_EXC;
      else if (eret)
         op = OP_ERET;
      else if (pend_v_q && !stall)
         op = OP_PEND;
      else if (stall)
         op = pend_v_q ? OP_SEQ : redirOp;
      else
         op = redirOp;
   end

   assign pcSeq   = pc_q + WIDTH'(4);
   assign loadTgt = (op == OP_PEND) ? pend_q : redirTgt;
   assign tgtLoad = !stall && (op == OP_BR || op == OP_JMP || op == OP_JR || op == OP_PEND);

   always_comb begin
      pc_d     = pc_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      if (op == OP_EXC || op == OP_ERET) begin
         pc_d     = (op == OP_EXC) ? EXC_VEC : epc;
         pend_v_d = 1'b0;
      end else if (tgtLoad) begin
         pc_d     = loadTgt;
         pend_v_d = 1'b0;
      end else if (stall) begin
         if (!pend_v_q && redirOp != OP_SEQ) begin
            pend_d   = redirTgt;
            pend_v_d = 1'b1;
         end
      end else begin
         pc_d = pcSeq;
      end
`ifdef PC_ALIGN_CHECK_EN
      if (tgtLoad && (loadTgt[1:0] != 2'b00))
         pc_d = EXC_VEC;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   logic misalign_q;

   // Raised only on the edge that diverts a misaligned target, so it lasts one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         misalign_q <= 1'b0;
      else
         misalign_q <= tgtLoad && (loadTgt[1:0] != 2'b00);
   end

   assign misalign = misalign_q;
`else
   assign misalign = 1'b0;
`endif

   assign pc     = pc_q;
   assign pc_op  = op;
   assign pend_v = pend_v_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Randomized and directed self-checking bench for pc_next_unit against a behavioural next-PC model.
// Expectations follow the PC_ALIGN_CHECK_EN build macro when it is defined.
module tb_pc_next_unit;

   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] EXCV   = 32'h0000_4180;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, br_taken, jump, jreg, exc, eret;
   logic [31:0] br_target, j_target, jr_target, epc;
   logic [31:0] pc;
   logic [2:0]  pc_op;
   logic        pend_v, misalign;

   int checks = 0;
   int errors = 0;

   // Reference state: architectural PC, the single buffered redirect and the misalign flag.
   logic [31:0] mPc;
   logic        mPendV;
   logic [31:0] mPendT;
   logic        mMis;

   pc_next_unit dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .br_taken(br_taken), .br_target(br_target),
      .jump(jump), .j_target(j_target),
      .jreg(jreg), .jr_target(jr_target),
      .exc(exc), .eret(eret), .epc(epc),
      .pc(pc), .pc_op(pc_op), .pend_v(pend_v), .misalign(misalign)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit alignCheckOn();
`ifdef PC_ALIGN_CHECK_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit anyRedirect();
      return br_taken || jump || jreg;
   endfunction

   function automatic logic [31:0] redirectTarget();
      if (br_taken) return br_target;
      if (jump)     return j_target;
      return jr_target;
   endfunction

   function automatic logic [2:0] redirectCode();
      if (br_taken) return 3'd1;
      if (jump)     return 3'd2;
      if (jreg)     return 3'd3;
      return 3'd0;
   endfunction

   function automatic logic [2:0] modelOp();
      if (exc)              return 3'd4;
      if (eret)             return 3'd5;
      if (mPendV && !stall) return 3'd6;
      if (stall && mPendV)  return 3'd0;
      return redirectCode();
   endfunction

   task automatic modelLoad(input logic [31:0] tgt);
      if (alignCheckOn() && tgt[1:0] != 2'b00) begin
         mPc  = EXCV;
         mMis = 1'b1;
      end else begin
         mPc = tgt;
      end
   endtask

   task automatic modelStep();
      mMis = 1'b0;
      if (exc) begin
         mPc = EXCV;  mPendV = 1'b0;
      end else if (eret) begin
         mPc = epc;   mPendV = 1'b0;
      end else if (stall) begin
         if (!mPendV && anyRedirect()) begin
            mPendT = redirectTarget();
            mPendV = 1'b1;
         end
      end else if (mPendV) begin
         mPendV = 1'b0;
         modelLoad(mPendT);
      end else if (anyRedirect()) begin
         modelLoad(redirectTarget());
      end else begin
         mPc = mPc + 32'd4;
      end
   endtask

   task automatic modelReset();
      mPc = RST_PC; mPendV = 1'b0; mPendT = '0; mMis = 1'b0;
   endtask

   // Called just after a rising edge: drive inputs, check pc_op mid-cycle, then the registered outputs.
   task automatic applyStimulus(input logic st, input logic br, input logic [31:0] bt,
                                input logic jp, input logic [31:0] jt,
                                input logic jr, input logic [31:0] jrt,
                                input logic ex, input logic er, input logic [31:0] ep);
      stall = st; br_taken = br; br_target = bt; jump = jp; j_target = jt;
      jreg = jr; jr_target = jrt; exc = ex; eret = er; epc = ep;
      @(negedge clk);
      checkOutput("pc_op", {29'd0, pc_op}, {29'd0, modelOp()});
      @(posedge clk);
      modelStep();
      #1;
      checkOutput("pc", pc, mPc);
      checkOutput("pend_v", {31'd0, pend_v}, {31'd0, mPendV});
      checkOutput("misalign", {31'd0, misalign}, {31'd0, mMis});
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 0; br_taken = 0; jump = 0; jreg = 0; exc = 0; eret = 0;
      br_target = 0; j_target = 0; jr_target = 0; epc = 0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_pc", pc, RST_PC);
      checkOutput("rst_pend_v", {31'd0, pend_v}, 32'd0);
      checkOutput("rst_misalign", {31'd0, misalign}, 32'd0);
      checkOutput("rst_pc_op", {29'd0, pc_op}, 32'd0);
      rst_n = 1'b1;

      // Sequential fetch after reset release.
      idle(); checkOutput("seq_1", pc, 32'h3004);
      idle(); checkOutput("seq_2", pc, 32'h3008);
      idle(); checkOutput("seq_3", pc, 32'h300C);

      // Branch beats jump in the same cycle.
      applyStimulus(0, 1, 32'h3100, 1, 32'h3200, 0, 0, 0, 0, 0);
      checkOutput("br_over_jump", pc, 32'h3100);

      // Buffer jreg during stall, ignore later jump, release.
      applyStimulus(1, 0, 0, 0, 0, 1, 32'h3400, 0, 0, 0);
      checkOutput("buf_pend", {31'd0, pend_v}, 32'd1);
      checkOutput("buf_hold", pc, 32'h3100);
      applyStimulus(1, 0, 0, 1, 32'h3800, 0, 0, 0, 0, 0);
      checkOutput("buf_keep", {31'd0, pend_v}, 32'd1);
      applyStimulus(0, 0, 0, 1, 32'h3900, 0, 0, 0, 0, 0);
      checkOutput("pend_release", pc, 32'h3400);

      // Exception during stall with pending redirect, then return.
      applyStimulus(1, 0, 0, 1, 32'h3600, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("exc_pc", pc, EXCV);
      checkOutput("exc_clr", {31'd0, pend_v}, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3010);
      checkOutput("eret_pc", pc, 32'h3010);

      // Wrap-around at the top of the address space.
      applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
      idle(); checkOutput("wrap", pc, 32'h0000_0000);

      // Misaligned jump target.
      applyStimulus(0, 0, 0, 1, 32'h3202, 0, 0, 0, 0, 0);
      checkOutput("mis_pc", pc, alignCheckOn() ? EXCV : 32'h3202);
      checkOutput("mis_flag", {31'd0, misalign}, {31'd0, alignCheckOn()});
      idle(); checkOutput("mis_clear", {31'd0, misalign}, 32'd0);

      // Reset mid-stall discards the buffered redirect.
      applyStimulus(1, 0, 0, 1, 32'h3500, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("rst_mid_pc", pc, RST_PC);
      checkOutput("rst_mid_pend", {31'd0, pend_v}, 32'd0);
      stall = 0; jump = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(); checkOutput("rst_resume", pc, 32'h3004);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] t0, t1, t2, e0;
         t0 = $urandom(); t1 = $urandom(); t2 = $urandom(); e0 = $urandom();
         if ($urandom_range(0, 7) != 0) t0[1:0] = 2'b00;
         if ($urandom_range(0, 7) != 0) t1[1:0] = 2'b00;
         if ($urandom_range(0, 7) != 0) t2[1:0] = 2'b00;
         e0[1:0] = 2'b00;
         applyStimulus($urandom_range(0, 9) < 4, $urandom_range(0, 4) == 0, t0,
                       $urandom_range(0, 4) == 0, t1, $urandom_range(0, 4) == 0, t2,
                       $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, e0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
